// File: rtl/eprisc_uart_pkg.sv
// Shared definitions for the epRISC UART sequencer: register map, control bits, FSM states.
package eprisc_uart_pkg;

   localparam logic [1:0] ADDR_CTRL = 2'd0;
   localparam logic [1:0] ADDR_TX   = 2'd1;
   localparam logic [1:0] ADDR_RX   = 2'd2;

   localparam int BIT_RECV_EN  = 5;
   localparam int BIT_RECV_INT = 6;
   localparam int BIT_SEND     = 7;

   typedef enum logic [2:0] {
      sInit,
      sIdle,
      sRxRead,
      sTxPoll,
      sTxLoad,
      sTxGo
   } state_t;

endpackage

// File: rtl/eprisc_uart_ctrl_fifo.sv
// Synchronous show-ahead FIFO; push into a full FIFO is accepted only alongside a pop.
module eprisc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [WIDTH-1:0] iData,
   input  logic             iPush,
   input  logic             iPop,
   output logic [WIDTH-1:0] oData,
   output logic             oFull,
   output logic             oEmpty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtrReg;
   logic [AW:0]      rdPtrReg;
   logic             doPush;
   logic             doPop;

   // Extra pointer MSB tells a wrapped (full) FIFO from an empty one
   assign oEmpty = (wrPtrReg == rdPtrReg);
   assign oFull  = (wrPtrReg[AW] != rdPtrReg[AW]) &&
                   (wrPtrReg[AW-1:0] == rdPtrReg[AW-1:0]);
   assign doPop  = iPop && !oEmpty;
   assign doPush = iPush && (!oFull || doPop);
   assign oData  = oEmpty ? '0 : mem[rdPtrReg[AW-1:0]];

   always_ff @(posedge iClk) begin
      if (doPush) begin
         mem[wrPtrReg[AW-1:0]] <= iData;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         wrPtrReg <= '0;
         rdPtrReg <= '0;
      end else begin
         if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
         if (doPop)  rdPtrReg <= rdPtrReg + 1'b1;
      end
   end

endmodule

// File: rtl/eprisc_uart_ctrl.sv
// Sequencer owning one epRISC UART register port: init write, TX poll/load/send, RX reads into a FIFO.
module eprisc_uart_ctrl
   import eprisc_uart_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter logic [15:0] CFG      = 16'h0060,
   parameter int          POLL_GAP = 4
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic [7:0]  iTxData,
   input  logic        iTxValid,
   output logic        oTxReady,
   output logic [7:0]  oRxData,
   output logic        oRxValid,
   input  logic        iRxReady,
   output logic        oRxOverrun,
   input  logic        iClrOverrun,
   output logic [1:0]  oUAddr,
   output logic [15:0] oUData,
   input  logic [15:0] iUData,
   output logic        oUWrite,
   output logic        oUEnable,
   input  logic        iUInt
);

   localparam int GW = $clog2(POLL_GAP + 1);

   state_t         stateReg, stateNext;
   logic           rxPendReg;
   logic           overrunReg;
   logic           txAvailReg;
   logic [GW-1:0]  gapCntReg;
   logic           txPush, txPop, txFull, txEmpty;
   logic [7:0]     txHead;
   logic           rxPush, rxPop, rxFull, rxEmpty;
   logic           uEnable, uWrite;
   logic [1:0]     uAddr;
   logic [15:0]    uData;
   logic           unusedUData;

   assign unusedUData = ^iUData[15:8];

   assign oTxReady   = !txFull;
   assign txPush     = iTxValid && !txFull;
   assign txPop      = (stateReg == sTxGo);
   assign rxPush     = (stateReg == sRxRead);
   assign rxPop      = !rxEmpty && iRxReady;
   assign oRxValid   = !rxEmpty;
   assign oRxOverrun = overrunReg;

   eprisc_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) txFifo (
      .iClk   (iClk),
      .iRst   (iRst),
      .iData  (iTxData),
      .iPush  (txPush),
      .iPop   (txPop),
      .oData  (txHead),
      .oFull  (txFull),
      .oEmpty (txEmpty)
   );

   eprisc_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) rxFifo (
      .iClk   (iClk),
      .iRst   (iRst),
      .iData  (iUData[7:0]),
      .iPush  (rxPush),
      .iPop   (rxPop),
      .oData  (oRxData),
      .oFull  (rxFull),
      .oEmpty (rxEmpty)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         stateReg   <= sInit;
         rxPendReg  <= 1'b0;
         gapCntReg  <= '0;
         overrunReg <= 1'b0;
         txAvailReg <= 1'b0;
      end else begin
         stateReg <= stateNext;
         if (iUInt)                    rxPendReg <= 1'b1;
         else if (stateReg == sRxRead) rxPendReg <= 1'b0;
         if (stateReg == sTxPoll && iUData[BIT_SEND]) gapCntReg <= GW'(POLL_GAP);
         else if (gapCntReg != '0)                    gapCntReg <= gapCntReg - GW'(1);
         if (rxPush && rxFull && !rxPop) overrunReg <= 1'b1;
         else if (iClrOverrun)           overrunReg <= 1'b0;
         // TX work is seen one cycle after it lands; never stale across the pop
         txAvailReg <= !txEmpty && !txPop;
      end
   end

   always_comb begin
      stateNext = stateReg;
      uEnable   = 1'b0;
      uWrite    = 1'b0;
      uAddr     = ADDR_CTRL;
      uData     = '0;
      case (stateReg)
         sInit: begin
            uEnable   = 1'b1;
            uWrite    = 1'b1;
            uData     = CFG;
            stateNext = sIdle;
         end
         sIdle: begin
            // gapCnt of 1 is the last idle gap cycle, so the retry poll lands right after it
            if (rxPendReg)                               stateNext = sRxRead;
            else if (txAvailReg && gapCntReg <= GW'(1))  stateNext = sTxPoll;
         end
         sRxRead: begin
            uEnable   = 1'b1;
            uAddr     = ADDR_RX;
            stateNext = sIdle;
         end
         sTxPoll: begin
            uEnable   = 1'b1;
            stateNext = iUData[BIT_SEND] ? sIdle : sTxLoad;
         end
         sTxLoad: begin
            uEnable   = 1'b1;
            uWrite    = 1'b1;
            uAddr     = ADDR_TX;
            uData     = {8'h00, txHead};
            stateNext = sTxGo;
         end
         sTxGo: begin
            uEnable   = 1'b1;
            uWrite    = 1'b1;
            uData     = CFG | (16'h0001 << BIT_SEND);
            stateNext = sIdle;
         end
         default: stateNext = sInit;
      endcase
   end

   // UART port is released as soon as reset is asserted, abandoning any access
   assign oUEnable = uEnable && !iRst;
   assign oUWrite  = uWrite && !iRst;
   assign oUAddr   = iRst ? ADDR_CTRL : uAddr;
   assign oUData   = iRst ? 16'h0000 : uData;

endmodule
